// File: rtl/ysyx_22040895_lsu_pkg.sv
// Shared types for the load/store unit: access sizes, response codes,
// controller states and the size-to-byte-count helper.
package ysyx_22040895_lsu_pkg;

   typedef enum logic [1:0] {
      SIZE_B = 2'b00,
      SIZE_H = 2'b01,
      SIZE_W = 2'b10,
      SIZE_D = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ERR_OK       = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_BUS      = 2'b10
   } err_e;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      RESP
   } state_e;

   // Number of bytes touched by an access of the given size encoding.
   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

endpackage

// File: rtl/ysyx_22040895_lsu_if.sv
// Request, response and memory-port signals of the load/store unit.
// The slave view belongs to the LSU, the master view to its surroundings.
interface ysyx_22040895_lsu_if #(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 64
);
   logic                req_valid_i;
   logic                req_ready_o;
   logic                req_we_i;
   logic [1:0]          req_size_i;
   logic                req_signed_i;
   logic [ADDR_W-1:0]   req_addr_i;
   logic [XLEN-1:0]     req_wdata_i;

   logic                resp_valid_o;
   logic                resp_ready_i;
   logic [XLEN-1:0]     resp_rdata_o;
   logic [1:0]          resp_err_o;

   logic                mem_req_o;
   logic                mem_gnt_i;
   logic                mem_we_o;
   logic [ADDR_W-1:0]   mem_addr_o;
   logic [XLEN-1:0]     mem_wdata_o;
   logic [XLEN/8-1:0]   mem_wstrb_o;
   logic                mem_rvalid_i;
   logic [XLEN-1:0]     mem_rdata_i;
   logic                mem_err_i;

   modport slave (
      input  req_valid_i, req_we_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i,
      input  resp_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
   );

   modport master (
      output req_valid_i, req_we_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i,
      output resp_ready_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
   );

endinterface

// File: rtl/ysyx_22040895_lsu_align.sv
// Byte-lane alignment: store strobes and shifted write data, load lane
// extraction with sign/zero extension, and the misalignment check.
module ysyx_22040895_lsu_align
   import ysyx_22040895_lsu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [$clog2(XLEN/8)-1:0] off_i,
   input  logic [1:0]                size_i,
   input  logic                      signed_i,
   input  logic [XLEN-1:0]           wdata_i,
   input  logic [XLEN-1:0]           rdata_i,
   output logic [XLEN/8-1:0]         wstrb_o,
   output logic [XLEN-1:0]           wdata_o,
   output logic [XLEN-1:0]           rdata_o,
   output logic                      misaligned_o
);
   localparam int STRB_W = XLEN / 8;

   logic [3:0]        nbytes;
   logic [STRB_W-1:0] one_hot;
   logic [XLEN-1:0]   rshift;

   assign nbytes  = size_bytes(size_i);
   // A full-width access shifts the 1 out, so the subtraction wraps to all ones.
   assign one_hot = STRB_W'(1) << nbytes;
   assign wstrb_o = (one_hot - STRB_W'(1)) << off_i;
   assign wdata_o = wdata_i << {off_i, 3'b000};
   assign rshift  = rdata_i >> {off_i, 3'b000};

   assign misaligned_o = ((4'(off_i) & (nbytes - 4'd1)) != 4'd0) ||
                         (XLEN == 32 && size_i == SIZE_D);

   // Truncate the shifted read data to the access size and extend it.
   always_comb begin
      // NOTE: assign a default before the case so no path leaves rdata_o unassigned and infers a latch.
      rdata_o = rshift;
      unique case (size_e'(size_i))
         SIZE_B: if (signed_i) rdata_o = XLEN'($signed(rshift[7:0]));
                 else          rdata_o = XLEN'(rshift[7:0]);
         SIZE_H: if (signed_i) rdata_o = XLEN'($signed(rshift[15:0]));
                 else          rdata_o = XLEN'(rshift[15:0]);
         SIZE_W: if (signed_i) rdata_o = XLEN'($signed(rshift[31:0]));
                 else          rdata_o = XLEN'(rshift[31:0]);
         SIZE_D: rdata_o = rshift;
      endcase
   end

endmodule

// File: rtl/ysyx_22040895_lsu.sv
// Load/store unit: request latch, IDLE/REQ/WAIT/RESP controller with
// registered outputs, and a bus timeout counter spanning REQ and WAIT.
module ysyx_22040895_lsu
   import ysyx_22040895_lsu_pkg::*;
#(
   parameter int XLEN           = 64,
   parameter int ADDR_W         = 64,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   ysyx_22040895_lsu_if.slave   bus
);
   localparam int STRB_W = XLEN / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e              state_q, state_d;
   logic                we_q, we_d;
   logic [1:0]          size_q, size_d;
   logic                signed_q, signed_d;
   logic [OFF_W-1:0]    off_q, off_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                req_ready_q, req_ready_d;
   logic                resp_valid_q, resp_valid_d;
   logic [XLEN-1:0]     resp_rdata_q, resp_rdata_d;
   logic [1:0]          resp_err_q, resp_err_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
   logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;

   logic [OFF_W-1:0]    al_off;
   logic [1:0]          al_size;
   logic                al_signed;
   logic [STRB_W-1:0]   al_wstrb;
   logic [XLEN-1:0]     al_wdata;
   logic [XLEN-1:0]     al_rdata;
   logic                al_misaligned;
   logic                timeout;

   // The aligner sees the incoming request while idle, the latched one afterwards.
   assign al_off    = (state_q == IDLE) ? bus.req_addr_i[OFF_W-1:0] : off_q;
   assign al_size   = (state_q == IDLE) ? bus.req_size_i            : size_q;
   assign al_signed = (state_q == IDLE) ? bus.req_signed_i          : signed_q;
   assign timeout   = (cnt_q == CNT_LAST);

   ysyx_22040895_lsu_align #(.XLEN(XLEN)) u_align (
      .off_i        (al_off),
      .size_i       (al_size),
      .signed_i     (al_signed),
      .wdata_i      (bus.req_wdata_i),
      .rdata_i      (bus.mem_rdata_i),
      .wstrb_o      (al_wstrb),
      .wdata_o      (al_wdata),
      .rdata_o      (al_rdata),
      .misaligned_o (al_misaligned)
   );

   // Next-state and next-output logic for the access controller.
   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      size_d       = size_q;
      signed_d     = signed_q;
      off_d        = off_q;
      cnt_d        = cnt_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wstrb_d  = mem_wstrb_q;

      unique case (state_q)
         IDLE: begin
            if (bus.req_valid_i) begin
               we_d        = bus.req_we_i;
               size_d      = bus.req_size_i;
               signed_d    = bus.req_signed_i;
               off_d       = al_off;
               req_ready_d = 1'b0;
               if (al_misaligned) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_rdata_d = '0;
                  resp_err_d   = ERR_MISALIGN;
               end else begin
                  state_d     = REQ;
                  cnt_d       = '0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = bus.req_we_i;
                  mem_addr_d  = {bus.req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  mem_wdata_d = al_wdata;
                  mem_wstrb_d = al_wstrb;
               end
            end
         end
         REQ: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (timeout) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = '0;
               resp_err_d   = ERR_BUS;
            end else if (bus.mem_gnt_i) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bus.mem_rvalid_i) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = (we_q || bus.mem_err_i) ? '0 : al_rdata;
               resp_err_d   = bus.mem_err_i ? ERR_BUS : ERR_OK;
            end else if (timeout) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = '0;
               resp_err_d   = ERR_BUS;
            end
         end
         RESP: begin
            if (bus.resp_ready_i) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
               resp_rdata_d = '0;
               resp_err_d   = ERR_OK;
               req_ready_d  = 1'b1;
            end
         end
      endcase

      // Memory-side outputs are only live while requesting.
      if (state_d != REQ) begin
         mem_req_d   = 1'b0;
         mem_we_d    = 1'b0;
         mem_addr_d  = '0;
         mem_wdata_d = '0;
         mem_wstrb_d = '0;
      end
   end

   // State, request latch, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: datapath registers are reset along with control because they drive outputs that must read 0 out of reset.
         state_q      <= IDLE;
         we_q         <= 1'b0;
         size_q       <= 2'b00;
         signed_q     <= 1'b0;
         off_q        <= '0;
         cnt_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= ERR_OK;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wstrb_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop updates from pre-edge values.
         state_q      <= state_d;
         we_q         <= we_d;
         size_q       <= size_d;
         signed_q     <= signed_d;
         off_q        <= off_d;
         cnt_q        <= cnt_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wstrb_q  <= mem_wstrb_d;
      end
   end

   assign bus.req_ready_o  = req_ready_q;
   assign bus.resp_valid_o = resp_valid_q;
   assign bus.resp_rdata_o = resp_rdata_q;
   assign bus.resp_err_o   = resp_err_q;
   assign bus.mem_req_o    = mem_req_q;
   assign bus.mem_we_o     = mem_we_q;
   assign bus.mem_addr_o   = mem_addr_q;
   assign bus.mem_wdata_o  = mem_wdata_q;
   assign bus.mem_wstrb_o  = mem_wstrb_q;

endmodule

// File: tb/tb_ysyx_22040895_lsu.sv
// Directed bench for the load/store unit (XLEN = 64, timeout of 16 cycles).
// Expected responses are queued when a request is driven and compared when
// the unit presents its response.
module tb_ysyx_22040895_lsu;
   import ysyx_22040895_lsu_pkg::*;

   localparam int XLEN   = 64;
   localparam int ADDR_W = 64;
   localparam int TO     = 16;

   typedef struct packed {
      logic [63:0] rdata;
      logic [1:0]  err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];

   ysyx_22040895_lsu_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

   ysyx_22040895_lsu #(
      .XLEN           (XLEN),
      .ADDR_W         (ADDR_W),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] exp_rdata, input logic [1:0] exp_err,
                           input bit expect_resp);
      check("req_ready_idle", 64'(bus.req_ready_o), 64'd1);
      bus.req_valid_i  = 1'b1;
      bus.req_we_i     = we;
      bus.req_size_i   = size;
      bus.req_signed_i = sgn;
      bus.req_addr_i   = addr;
      bus.req_wdata_i  = wdata;
      if (expect_resp) sb.push_back('{rdata: exp_rdata, err: exp_err});
      step();
      bus.req_valid_i = 1'b0;
   endtask

   task automatic mem_txn(input int gnt_delay, input logic [63:0] rdata, input logic err);
      repeat (gnt_delay) step();
      bus.mem_gnt_i = 1'b1;
      step();
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = rdata;
      bus.mem_err_i    = err;
      step();
      bus.mem_rvalid_i = 1'b0;
      bus.mem_err_i    = 1'b0;
   endtask

   task automatic wait_resp(input string tag, input int max_wait, input int exp_wait);
      int   waited;
      exp_t e;
      waited = 0;
      while (bus.resp_valid_o !== 1'b1 && waited < max_wait) begin
         step();
         waited++;
      end
      check({tag, "_latency"}, 64'(waited), 64'(exp_wait));
      check({tag, "_valid"}, 64'(bus.resp_valid_o), 64'd1);
      if (bus.resp_valid_o === 1'b1) begin
         check({tag, "_expected"}, 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_rdata"}, bus.resp_rdata_o, e.rdata);
            check({tag, "_err"}, 64'(bus.resp_err_o), 64'(e.err));
         end
         bus.resp_ready_i = 1'b1;
         step();
         check({tag, "_drop"}, 64'(bus.resp_valid_o), 64'd0);
      end
   endtask

   initial begin
      int n;
      bus.req_valid_i  = 1'b0;
      bus.req_we_i     = 1'b0;
      bus.req_size_i   = 2'b00;
      bus.req_signed_i = 1'b0;
      bus.req_addr_i   = '0;
      bus.req_wdata_i  = '0;
      bus.resp_ready_i = 1'b1;
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = '0;
      bus.mem_err_i    = 1'b0;

      // Reset values.
      step();
      step();
      check("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
      check("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
      check("rst_mem_req", 64'(bus.mem_req_o), 64'd0);
      check("rst_wstrb", 64'(bus.mem_wstrb_o), 64'd0);
      check("rst_err", 64'(bus.resp_err_o), 64'd0);
      rst = 1'b0;
      step();

      // Store byte at offset 3.
      send_req(1'b1, SIZE_B, 1'b0, 64'h8000_0003, 64'hAB, 64'd0, ERR_OK, 1'b1);
      check("st_b_mem_req", 64'(bus.mem_req_o), 64'd1);
      check("st_b_mem_we", 64'(bus.mem_we_o), 64'd1);
      check("st_b_addr", bus.mem_addr_o, 64'h8000_0000);
      check("st_b_wstrb", 64'(bus.mem_wstrb_o), 64'h08);
      check("st_b_wdata", bus.mem_wdata_o, 64'h0000_0000_AB00_0000);
      check("st_b_req_ready", 64'(bus.req_ready_o), 64'd0);
      mem_txn(0, 64'h1122_3344_5566_7788, 1'b0);
      wait_resp("st_b", 4, 0);

      // Half loads at offset 6, signed then unsigned with a delayed grant.
      send_req(1'b0, SIZE_H, 1'b1, 64'h8000_0006, 64'd0, 64'hFFFF_FFFF_FFFF_8001, ERR_OK, 1'b1);
      check("ld_hs_wstrb", 64'(bus.mem_wstrb_o), 64'hC0);
      check("ld_hs_mem_we", 64'(bus.mem_we_o), 64'd0);
      mem_txn(0, 64'h8001_0000_0000_0000, 1'b0);
      wait_resp("ld_hs", 4, 0);

      send_req(1'b0, SIZE_H, 1'b0, 64'h8000_0006, 64'd0, 64'h0000_0000_0000_8001, ERR_OK, 1'b1);
      step();
      step();
      check("ld_hu_hold_req", 64'(bus.mem_req_o), 64'd1);
      check("ld_hu_hold_addr", bus.mem_addr_o, 64'h8000_0000);
      mem_txn(0, 64'h8001_0000_0000_0000, 1'b0);
      wait_resp("ld_hu", 4, 0);

      // Double load ignores the signed flag; word and byte extraction.
      send_req(1'b0, SIZE_D, 1'b1, 64'h8000_0008, 64'd0, 64'hF000_0000_0000_0001, ERR_OK, 1'b1);
      check("ld_d_addr", bus.mem_addr_o, 64'h8000_0008);
      check("ld_d_wstrb", 64'(bus.mem_wstrb_o), 64'hFF);
      mem_txn(0, 64'hF000_0000_0000_0001, 1'b0);
      wait_resp("ld_d", 4, 0);

      send_req(1'b0, SIZE_W, 1'b1, 64'h8000_0004, 64'd0, 64'hFFFF_FFFF_8765_4321, ERR_OK, 1'b1);
      mem_txn(0, 64'h8765_4321_0000_0000, 1'b0);
      wait_resp("ld_ws", 4, 0);

      send_req(1'b0, SIZE_B, 1'b0, 64'h8000_0001, 64'd0, 64'h0000_0000_0000_00F2, ERR_OK, 1'b1);
      mem_txn(0, 64'h0000_0000_0000_F200, 1'b0);
      wait_resp("ld_bu", 4, 0);

      // Misaligned accesses never reach memory.
      send_req(1'b0, SIZE_W, 1'b0, 64'h8000_0002, 64'd0, 64'd0, ERR_MISALIGN, 1'b1);
      check("mis_w_mem_req", 64'(bus.mem_req_o), 64'd0);
      wait_resp("mis_w", 2, 0);

      send_req(1'b1, SIZE_H, 1'b0, 64'h8000_0005, 64'h1234, 64'd0, ERR_MISALIGN, 1'b1);
      check("mis_h_mem_req", 64'(bus.mem_req_o), 64'd0);
      check("mis_h_wstrb", 64'(bus.mem_wstrb_o), 64'd0);
      wait_resp("mis_h", 2, 0);

      // Store double answered with a bus error.
      send_req(1'b1, SIZE_D, 1'b0, 64'h8000_0010, 64'hCAFE_F00D_1234_5678, 64'd0, ERR_BUS, 1'b1);
      check("st_d_wdata", bus.mem_wdata_o, 64'hCAFE_F00D_1234_5678);
      check("st_d_wstrb", 64'(bus.mem_wstrb_o), 64'hFF);
      mem_txn(0, 64'h5555_5555_5555_5555, 1'b1);
      wait_resp("st_d_err", 4, 0);

      // Grant never arrives: timeout, late completion ignored, then a normal access.
      send_req(1'b0, SIZE_W, 1'b0, 64'h8000_0020, 64'd0, 64'd0, ERR_BUS, 1'b1);
      n = 0;
      while (bus.mem_req_o === 1'b1 && n < 40) begin
         n++;
         step();
      end
      check("to_req_cycles", 64'(n), 64'(TO));
      wait_resp("timeout", 2, 0);
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 64'hBAD0_BAD0_BAD0_BAD0;
      step();
      bus.mem_rvalid_i = 1'b0;
      check("late_rvalid_resp", 64'(bus.resp_valid_o), 64'd0);
      send_req(1'b0, SIZE_W, 1'b0, 64'h8000_0020, 64'd0, 64'h0000_0000_DEAD_BEEF, ERR_OK, 1'b1);
      mem_txn(1, 64'h1234_5678_DEAD_BEEF, 1'b0);
      wait_resp("after_to", 4, 0);

      // Response backpressure with a new request waiting.
      bus.resp_ready_i = 1'b0;
      send_req(1'b0, SIZE_B, 1'b1, 64'h8000_0007, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, ERR_OK, 1'b1);
      mem_txn(0, 64'h8000_0000_0000_0000, 1'b0);
      bus.req_valid_i  = 1'b1;
      bus.req_we_i     = 1'b0;
      bus.req_size_i   = SIZE_H;
      bus.req_signed_i = 1'b0;
      bus.req_addr_i   = 64'h8000_0001;
      sb.push_back('{rdata: 64'd0, err: ERR_MISALIGN});
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 64'(bus.resp_valid_o), 64'd1);
         check("bp_rdata", bus.resp_rdata_o, 64'hFFFF_FFFF_FFFF_FF80);
         check("bp_err", 64'(bus.resp_err_o), 64'(ERR_OK));
         check("bp_req_ready", 64'(bus.req_ready_o), 64'd0);
         step();
      end
      wait_resp("bp", 0, 0);
      check("bp_next_ready", 64'(bus.req_ready_o), 64'd1);
      step();
      bus.req_valid_i = 1'b0;
      wait_resp("bp_next", 2, 0);

      // Reset while requesting.
      send_req(1'b0, SIZE_W, 1'b0, 64'h8000_0040, 64'd0, 64'd0, ERR_OK, 1'b0);
      check("rst_req_mem_req", 64'(bus.mem_req_o), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_req_mem_req_drop", 64'(bus.mem_req_o), 64'd0);
      check("rst_req_ready", 64'(bus.req_ready_o), 64'd1);

      // Reset while waiting; the later completion must produce nothing.
      send_req(1'b0, SIZE_D, 1'b0, 64'h8000_0030, 64'd0, 64'd0, ERR_OK, 1'b0);
      bus.mem_gnt_i = 1'b1;
      step();
      bus.mem_gnt_i = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_wait_mem_req", 64'(bus.mem_req_o), 64'd0);
      check("rst_wait_resp_valid", 64'(bus.resp_valid_o), 64'd0);
      check("rst_wait_req_ready", 64'(bus.req_ready_o), 64'd1);
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 64'h0123_4567_89AB_CDEF;
      step();
      bus.mem_rvalid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("rst_wait_no_resp", 64'(bus.resp_valid_o), 64'd0);
         step();
      end

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ysyx_22040895_lsu.md
Name: ysyx_22040895_lsu

Overview:
Parametrised load/store unit that replaces the single-cycle memory access stage.
- Accepts one load or store per valid/ready handshake from the execute stage.
- Drives a req/gnt/rvalid memory port with byte-lane alignment and write strobes.
- Returns sign- or zero-extended load data, or an error code, on a valid/ready response channel.
- Adds behaviour the previous generation lacked: misalignment detection, signed loads, backpressure and bus timeout.

Parameters:
XLEN, 64, data width in bits; legal values are 32 and 64.
ADDR_W, 64, address width.
TIMEOUT_CYCLES, 256, cycles allowed in REQ+WAIT before the access is abandoned; must be ≥ 2.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  unit can accept a request
req_we_i  in  1  1 = store, 0 = load
req_size_i  in  2  00 byte, 01 half, 10 word, 11 double
req_signed_i  in  1  loads only: sign-extend when 1
req_addr_i  in  ADDR_W  byte address
req_wdata_i  in  XLEN  store data, right-aligned
resp_valid_o  out  1  response valid
resp_ready_i  in  1  consumer accepts the response
resp_rdata_o  out  XLEN  extended load data; 0 for stores and errors
resp_err_o  out  2  00 ok, 01 misaligned, 10 bus error/timeout
mem_req_o  out  1  memory request
mem_gnt_i  in  1  request granted
mem_we_o  out  1  write enable
mem_addr_o  out  ADDR_W  address aligned down to XLEN/8 bytes
mem_wdata_o  out  XLEN  lane-shifted write data
mem_wstrb_o  out  XLEN/8  byte strobes
mem_rvalid_i  in  1  completion for both loads and stores
mem_rdata_i  in  XLEN  full-word read data
mem_err_i  in  1  bus error, qualified by mem_rvalid_i

Behaviour:
- Reset: all outputs 0 except req_ready_o = 1; state IDLE; timeout counter 0.
- FSM states and transitions:
  - IDLE: req_ready_o = 1. On req_valid_i, latch all request fields.
    - Misaligned request goes to RESP with err 01.
    - Otherwise go to REQ.
  - REQ: mem_req_o = 1 and all mem_* outputs held stable until mem_gnt_i. On the grant cycle go to WAIT.
  - WAIT: wait for mem_rvalid_i, then go to RESP.
    - Latch the extended load data.
    - err = 10 if mem_err_i is set, else 00.
  - RESP: resp_valid_o = 1 with data and err held stable until resp_ready_i, then go to IDLE.
    - No new request is accepted in the cycle of the response handshake.
- Alignment: offset = addr mod (XLEN/8). Access is misaligned if addr mod size_bytes ≠ 0. Size 11 with XLEN = 32 is also reported as misaligned. A misaligned access issues no memory traffic.
- Store lane mapping:
  - mem_wstrb_o = ((1 << size_bytes) − 1) << offset.
  - mem_wdata_o = req_wdata << (8·offset); bits outside the strobes are don't-care but driven deterministically.
- Loads:
  - Extract (mem_rdata_i >> 8·offset) and truncate to the access size.
  - Extend with the latched signed flag. Double-word loads ignore the signed flag.
  - For loads, mem_wstrb_o reflects the access size.
- Latency:
  - Accepted at edge 0, mem_req_o high in cycle 1.
  - With gnt in cycle 1 and rvalid in cycle 2, resp_valid_o is high in cycle 3.
  - Misaligned: resp_valid_o is high in cycle 1.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES, go to RESP with err 10; mem_req_o drops the same edge.
- Stray inputs: mem_rvalid_i outside WAIT is ignored, including late responses after a timeout. mem_gnt_i outside REQ is ignored.
- Reset mid-operation: the transaction is abandoned. All outputs return to reset values at that edge; no response is ever issued for it.

Decomposition:
- Package ysyx_22040895_lsu_pkg:
  - size encodings;
  - err codes;
  - FSM state enum (IDLE, REQ, WAIT, RESP);
  - function size_bytes(size).
- Sub-module ysyx_22040895_lsu_align: purely combinational.
  - Inputs: addr offset, size, signed, wdata, rdata.
  - Outputs: wstrb, shifted wdata, extended rdata, misaligned flag.
- The top level holds the FSM, the request latch and the timeout counter.

Test Plan:
All scenarios use XLEN = 64.
- Store byte, addr 0x8000_0003, wdata 0xAB, gnt immediate, rvalid next cycle → mem_addr 0x8000_0000, wstrb 0x08, wdata 0x0000_0000_AB00_0000; resp_valid in cycle 3, err 00, rdata 0.
- Load half signed, addr 0x8000_0006, mem_rdata 0x8001_0000_0000_0000 → rdata 0xFFFF_FFFF_FFFF_8001. The same load unsigned → 0x0000_0000_0000_8001.
- Load word, addr 0x8000_0002 → mem_req never asserted; resp_valid in cycle 1 with err 01 and rdata 0.
- TIMEOUT_CYCLES = 16 and gnt never asserted → mem_req high for exactly 16 cycles, then resp err 10. A later rvalid is ignored and the next request completes normally.
- resp_ready held low for 5 cycles → resp_valid, rdata and err stable; req_ready 0 throughout. A new request is accepted in the cycle after the response handshake.
- rst asserted during WAIT → next cycle mem_req 0, resp_valid 0, req_ready 1. A subsequent mem_rvalid produces no response.
